ccx_ic_xbar: RTL and testbench
==============================

Name: ccx_ic_xbar

Overview:
Parametrised NI-initiator by NT-target memory crossbar for the core complex. It generalises the fixed imem/dmem to ROM/RAM/EXT/MMIO interconnect to any number of initiators and address-mapped targets. Each target has its own round-robin arbiter with hold-until-grant locking. A per-initiator response tracker routes one-cycle-latency responses back to the correct initiator. Unmapped addresses receive a locally generated error response.

Parameters:
NI, 2, number of initiator ports (1..8)
NT, 4, number of target ports (1..8)
AW, 39, address width
DW, 64, data width; SW = DW/8 strobe width
TGT_BASE, {39'h10000000,39'h20000,39'h10000,39'h0}, packed NT*AW base addresses, target t at slice t
TGT_MASK, {~39'h0FFFFFFF,~39'hFF,~39'hFFFF,~39'h3FF}, packed NT*AW address masks, target t at slice t

Ports:
g_clk  in  1  global clock
g_resetn  in  1  synchronous active-low reset
i_req  in  NI  initiator request
i_addr  in  NI*AW  initiator address
i_wen  in  NI  initiator write enable
i_strb  in  NI*SW  initiator write strobe
i_wdata  in  NI*DW  initiator write data
i_gnt  out  NI  request accepted this cycle
i_err  out  NI  response error, valid the cycle after acceptance
i_rdata  out  NI*DW  response read data, valid the cycle after acceptance
t_req  out  NT  target request
t_addr  out  NT*AW  target address
t_wen  out  NT  target write enable
t_strb  out  NT*SW  target write strobe
t_wdata  out  NT*DW  target write data
t_gnt  in  NT  target accepted
t_err  in  NT  target response error, cycle after t_gnt
t_rdata  in  NT*DW  target response data, cycle after t_gnt

Behaviour:
- Protocol, all ports: a transfer occurs when req and gnt are both high. Initiators hold req, addr, wen, strb and wdata stable until gnt. The response (rdata, err) is valid exactly one cycle after the transfer. Back-to-back transfers are allowed.
- Decode: initiator i hits target t when (i_addr & TGT_MASK[t]) == TGT_BASE[t]. On overlapping hits, the lowest t wins. No hit means a decode error.
- Per-target arbitration: round-robin over the initiators that decode to t. Priority starts at the initiator after the last winner. The pointer is 0 after reset.
- Per-target lock: if t_req=1 and t_gnt=0, the current owner is held until t_gnt=1, so t_addr/t_wdata stay stable and no re-arbitration happens. On a transfer, the pointer advances to owner+1, wrapping at NI.
- Forwarding is combinational and zero-latency: t_* equals the owner's signals. i_gnt[owner] = t_gnt[t]. Non-owners get i_gnt=0.
- Decode error: i_gnt=1 in the same cycle and no t_req is raised. Next cycle: i_err=1, i_rdata=0.
- Response tracking: per initiator, registered rsp_vld plus rsp_src (target index or DECERR), captured on that initiator's transfer. Next cycle, i_rdata/i_err are muxed from t_rdata/t_err[rsp_src].
- When rsp_vld=0: i_err=0 and i_rdata=0.
- Independent targets serve different initiators in the same cycle.
- Reset (g_resetn=0): t_req=0, i_gnt=0, i_err=0, i_rdata=0, all pointers and locks cleared, rsp_vld=0.
- A response pending across reset is discarded. The first cycle after reset release has no responses.
- Arbitration, locking and forwarding are combinational from the current inputs plus registered state. There are no combinational paths from t_rdata to any t_* output.

Decomposition:
- Package ccx_ic_pkg: AW/DW defaults, SW derivation, the DECERR source encoding, and the default base/mask constants for ROM, RAM, MMIO and EXT.
- Sub-module ccx_ic_rr_arb, instantiated once per target. It contains the NI-way round-robin arbiter with request vector, lock on stall, advance on transfer, and a one-hot plus binary owner output.
- The decoder and response tracker stay in ccx_ic_xbar, in generate loops.

Test Plan:
1. i0 reads 0x10008, RAM t_gnt=1 -> same cycle t_req[1]=1, t_addr=0x10008, i_gnt[0]=1. Next cycle RAM t_rdata=0xDEADBEEF_CAFEF00D appears on i_rdata[0], i_err[0]=0.
2. i0 and i1 both continuously request RAM with t_gnt=1 from reset -> grants go i0,i1,i0,i1. Each i_rdata returns the matching target data one cycle later.
3. RAM t_gnt=0 for 3 cycles with i0 owner and i1 waiting; i1 then retargets ROM 0x8 -> RAM t_addr stays at i0's address. i1 is granted by ROM immediately while RAM is stalled. i0 is granted when t_gnt rises.
4. i1 accesses 0x40000000 -> i_gnt[1]=1 same cycle with no t_req. Next cycle i_err[1]=1, i_rdata[1]=0.
5. MMIO returns t_err=1 for i0 while i1 reads ROM in the same cycle -> i_err[0]=1 and i_err[1]=0, each initiator getting its own rdata.
6. g_resetn=0 in the cycle after an i0 RAM grant -> i_err and i_rdata stay 0 with no response delivered. After release, the first contention grants i0 because the pointer is reset.

Source files
------------

// File: rtl/ccx_ic_pkg.sv
// Shared constants for the core-complex crossbar: default widths, response-source encoding, default memory map.
// Memory map: ROM 0x0/1KiB, RAM 0x10000/64KiB, MMIO 0x20000/256B, EXT 0x10000000/256MiB.
package ccx_ic_pkg;

    localparam int DEF_AW = 39;
    localparam int DEF_DW = 64;

    // Response source: target index 0..7, or a locally generated decode error.
    localparam int              SRCW       = 4;
    localparam logic [SRCW-1:0] SRC_DECERR = 4'd8;

    localparam logic [DEF_AW-1:0] ROM_BASE  = 39'h0;
    localparam logic [DEF_AW-1:0] ROM_MASK  = ~39'h3FF;
    localparam logic [DEF_AW-1:0] RAM_BASE  = 39'h10000;
    localparam logic [DEF_AW-1:0] RAM_MASK  = ~39'hFFFF;
    localparam logic [DEF_AW-1:0] MMIO_BASE = 39'h20000;
    localparam logic [DEF_AW-1:0] MMIO_MASK = ~39'hFF;
    localparam logic [DEF_AW-1:0] EXT_BASE  = 39'h10000000;
    localparam logic [DEF_AW-1:0] EXT_MASK  = ~39'h0FFFFFFF;

    localparam logic [4*DEF_AW-1:0] DEF_TGT_BASE = {EXT_BASE, MMIO_BASE, RAM_BASE, ROM_BASE};
    localparam logic [4*DEF_AW-1:0] DEF_TGT_MASK = {EXT_MASK, MMIO_MASK, RAM_MASK, ROM_MASK};

    function automatic int sw_of(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/ccx_ic_rr_arb.sv
// NI-way round-robin arbiter for one target; owner is combinational (zero latency) from requests plus state.
// A stalled owner (no target gnt) stays locked until granted; the pointer advances past the owner on each transfer.
module ccx_ic_rr_arb #(
    parameter int NI = 2,
    parameter int IW = (NI > 1) ? $clog2(NI) : 1
) (
    input  logic          g_clk,
    input  logic          g_resetn,
    input  logic [NI-1:0] i_req,
    input  logic          i_gnt,
    output logic          o_vld,
    output logic [NI-1:0] o_own_oh,
    output logic [IW-1:0] o_own_idx
);

    logic [IW-1:0] r_ptr;
    logic          r_lock;
    logic [IW-1:0] r_lock_idx;

    logic          w_vld;
    logic [IW-1:0] w_idx;
    int            w_dist;
    int            w_best;

    // Winner is the requester at the smallest rotational distance from the pointer.
    always_comb begin
        w_vld  = 1'b0;
        w_idx  = '0;
        w_dist = 0;
        w_best = NI;
        if (r_lock && i_req[r_lock_idx]) begin
            w_vld = 1'b1;
            w_idx = r_lock_idx;
        end else begin
            for (int c = 0; c < NI; c++) begin
                w_dist = (c + NI - int'(r_ptr)) % NI;
                if (i_req[c] && (w_dist < w_best)) begin
                    w_best = w_dist;
                    w_vld  = 1'b1;
                    w_idx  = IW'(c);
                end
            end
        end
    end

    always_comb begin
        o_own_oh = '0;
        for (int c = 0; c < NI; c++) begin
            o_own_oh[c] = w_vld && (w_idx == IW'(c));
        end
    end

    assign o_vld     = w_vld;
    assign o_own_idx = w_idx;

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            r_ptr      <= '0;
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
        end else if (w_vld) begin
            if (i_gnt) begin
                r_ptr  <= (w_idx == IW'(NI - 1)) ? '0 : w_idx + 1'b1;
                r_lock <= 1'b0;
            end else begin
                r_lock     <= 1'b1;
                r_lock_idx <= w_idx;
            end
        end
    end

endmodule

// File: rtl/ccx_ic_xbar.sv
// NI x NT address-decoded crossbar: zero-latency request forwarding, one-cycle responses routed by a per-initiator tracker.
// Backpressure: t_gnt low stalls and locks that target's owner; unmapped addresses are granted at once and answered with err.
module ccx_ic_xbar
    import ccx_ic_pkg::*;
#(
    parameter int              NI       = 2,
    parameter int              NT       = 4,
    parameter int              AW       = DEF_AW,
    parameter int              DW       = DEF_DW,
    parameter logic [NT*AW-1:0] TGT_BASE = DEF_TGT_BASE,
    parameter logic [NT*AW-1:0] TGT_MASK = DEF_TGT_MASK,
    localparam int             SW       = sw_of(DW),
    localparam int             IW       = (NI > 1) ? $clog2(NI) : 1
) (
    input  logic             g_clk,
    input  logic             g_resetn,
    input  logic [NI-1:0]    i_req,
    input  logic [NI*AW-1:0] i_addr,
    input  logic [NI-1:0]    i_wen,
    input  logic [NI*SW-1:0] i_strb,
    input  logic [NI*DW-1:0] i_wdata,
    output logic [NI-1:0]    i_gnt,
    output logic [NI-1:0]    i_err,
    output logic [NI*DW-1:0] i_rdata,
    output logic [NT-1:0]    t_req,
    output logic [NT*AW-1:0] t_addr,
    output logic [NT-1:0]    t_wen,
    output logic [NT*SW-1:0] t_strb,
    output logic [NT*DW-1:0] t_wdata,
    input  logic [NT-1:0]    t_gnt,
    input  logic [NT-1:0]    t_err,
    input  logic [NT*DW-1:0] t_rdata
);

    logic [NI-1:0]   w_dec_err;
    logic [SRCW-1:0] w_tsel [NI];
    logic [NI-1:0]   w_treq [NT];
    logic            w_own_vld [NT];
    logic [NI-1:0]   w_own_oh [NT];
    logic [IW-1:0]   w_own_idx [NT];
    logic [NI-1:0]   w_gnt;

    logic [NI-1:0]   r_rsp_vld;
    logic [SRCW-1:0] r_rsp_src [NI];

    // Scan from the top so the lowest matching target overrides.
    always_comb begin
        w_dec_err = '1;
        for (int i = 0; i < NI; i++) begin
            w_tsel[i] = '0;
            for (int t = NT - 1; t >= 0; t--) begin
                if ((i_addr[i*AW +: AW] & TGT_MASK[t*AW +: AW]) == TGT_BASE[t*AW +: AW]) begin
                    w_dec_err[i] = 1'b0;
                    w_tsel[i]    = SRCW'(t);
                end
            end
        end
    end

    always_comb begin
        for (int t = 0; t < NT; t++) begin
            w_treq[t] = '0;
            for (int i = 0; i < NI; i++) begin
                w_treq[t][i] = i_req[i] && !w_dec_err[i] && (w_tsel[i] == SRCW'(t));
            end
        end
    end

    for (genvar t = 0; t < NT; t++) begin : g_arb
        ccx_ic_rr_arb #(
            .NI (NI),
            .IW (IW)
        ) u_arb (
            .g_clk     (g_clk),
            .g_resetn  (g_resetn),
            .i_req     (w_treq[t]),
            .i_gnt     (t_gnt[t]),
            .o_vld     (w_own_vld[t]),
            .o_own_oh  (w_own_oh[t]),
            .o_own_idx (w_own_idx[t])
        );
    end

    always_comb begin
        t_req   = '0;
        t_addr  = '0;
        t_wen   = '0;
        t_strb  = '0;
        t_wdata = '0;
        for (int t = 0; t < NT; t++) begin
            t_req[t] = g_resetn && w_own_vld[t];
            for (int i = 0; i < NI; i++) begin
                if (w_own_idx[t] == IW'(i)) begin
                    t_addr[t*AW +: AW]  = i_addr[i*AW +: AW];
                    t_wen[t]            = i_wen[i];
                    t_strb[t*SW +: SW]  = i_strb[i*SW +: SW];
                    t_wdata[t*DW +: DW] = i_wdata[i*DW +: DW];
                end
            end
        end
    end

    always_comb begin
        w_gnt = '0;
        for (int i = 0; i < NI; i++) begin
            if (g_resetn && i_req[i]) begin
                if (w_dec_err[i]) begin
                    w_gnt[i] = 1'b1;
                end else begin
                    for (int t = 0; t < NT; t++) begin
                        if (w_tsel[i] == SRCW'(t)) begin
                            w_gnt[i] = t_gnt[t] && w_own_oh[t][i];
                        end
                    end
                end
            end
        end
    end

    assign i_gnt = w_gnt;

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            r_rsp_vld <= '0;
            for (int i = 0; i < NI; i++) begin
                r_rsp_src[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                r_rsp_vld[i] <= i_req[i] && w_gnt[i];
                if (i_req[i] && w_gnt[i]) begin
                    r_rsp_src[i] <= w_dec_err[i] ? SRC_DECERR : w_tsel[i];
                end
            end
        end
    end

    // Outputs are gated with reset so a response in flight when reset hits is dropped.
    always_comb begin
        i_err   = '0;
        i_rdata = '0;
        for (int i = 0; i < NI; i++) begin
            if (g_resetn && r_rsp_vld[i]) begin
                if (r_rsp_src[i] == SRC_DECERR) begin
                    i_err[i] = 1'b1;
                end else begin
                    for (int t = 0; t < NT; t++) begin
                        if (r_rsp_src[i] == SRCW'(t)) begin
                            i_err[i]            = t_err[t];
                            i_rdata[i*DW +: DW] = t_rdata[t*DW +: DW];
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ccx_ic_xbar.sv
// Randomized bench for ccx_ic_xbar against a transaction-level model of decode, round-robin ownership and response routing.
module tb_ccx_ic_xbar;

    localparam int NI = 2;
    localparam int NT = 4;
    localparam int AW = 39;
    localparam int DW = 64;
    localparam int SW = 8;

    logic             g_clk = 1'b0;
    logic             g_resetn;
    logic [NI-1:0]    i_req;
    logic [NI*AW-1:0] i_addr;
    logic [NI-1:0]    i_wen;
    logic [NI*SW-1:0] i_strb;
    logic [NI*DW-1:0] i_wdata;
    logic [NI-1:0]    i_gnt;
    logic [NI-1:0]    i_err;
    logic [NI*DW-1:0] i_rdata;
    logic [NT-1:0]    t_req;
    logic [NT*AW-1:0] t_addr;
    logic [NT-1:0]    t_wen;
    logic [NT*SW-1:0] t_strb;
    logic [NT*DW-1:0] t_wdata;
    logic [NT-1:0]    t_gnt;
    logic [NT-1:0]    t_err;
    logic [NT*DW-1:0] t_rdata;

    ccx_ic_xbar #(
        .NI (NI),
        .NT (NT)
    ) dut (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_wen    (i_wen),
        .i_strb   (i_strb),
        .i_wdata  (i_wdata),
        .i_gnt    (i_gnt),
        .i_err    (i_err),
        .i_rdata  (i_rdata),
        .t_req    (t_req),
        .t_addr   (t_addr),
        .t_wen    (t_wen),
        .t_strb   (t_strb),
        .t_wdata  (t_wdata),
        .t_gnt    (t_gnt),
        .t_err    (t_err),
        .t_rdata  (t_rdata)
    );

    always #5 g_clk = ~g_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Pending transaction per initiator, held until the model says it was granted.
    bit            p_act   [NI];
    logic [AW-1:0] p_addr  [NI];
    bit            p_wen   [NI];
    logic [SW-1:0] p_strb  [NI];
    logic [DW-1:0] p_wdata [NI];

    // Model state: next-priority initiator and stalled owner (-1 = none) per target,
    // plus the outstanding response source per initiator (-1 = decode error).
    int m_ptr  [NT];
    int m_hold [NT];
    bit m_vld  [NI];
    int m_src  [NI];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int decode(input logic [AW-1:0] a);
        if ((a & ~39'h3FF) == 39'h0)             return 0;
        if ((a & ~39'hFFFF) == 39'h10000)        return 1;
        if ((a & ~39'hFF) == 39'h20000)          return 2;
        if ((a & ~39'h0FFFFFFF) == 39'h10000000) return 3;
        return -1;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] a;
        logic [63:0]   r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 9))
            0:       a = AW'($urandom_range(0, 127)) << 3;
            1, 2, 3: a = 39'h10000 + (AW'($urandom_range(0, 8191)) << 3);
            4:       a = 39'h20000 + (AW'($urandom_range(0, 31)) << 3);
            5:       a = 39'h10000000 + (AW'($urandom) & 39'h0FFFFFF8);
            6:       a = 39'h40000000;
            7:       a = r[AW-1:0];
            8:       a = ($urandom_range(0, 1) == 1) ? 39'h400 : 39'h20100;
            default: a = 39'h1FFF8;
        endcase
        return a;
    endfunction

    task automatic eval_cycle();
        int            tgt [NI];
        int            own [NT];
        int            c;
        logic [NI-1:0] e_gnt;
        logic [NT-1:0] e_treq;
        logic [DW-1:0] e_rd;
        logic          e_err;

        for (int i = 0; i < NI; i++) begin
            tgt[i] = p_act[i] ? decode(p_addr[i]) : -2;
        end
        e_gnt  = '0;
        e_treq = '0;
        for (int t = 0; t < NT; t++) begin
            own[t] = -1;
            if (g_resetn) begin
                if (m_hold[t] >= 0 && tgt[m_hold[t]] == t) begin
                    own[t] = m_hold[t];
                end else begin
                    for (int k = 0; k < NI; k++) begin
                        c = (m_ptr[t] + k) % NI;
                        if (own[t] < 0 && tgt[c] == t) own[t] = c;
                    end
                end
            end
            if (own[t] >= 0) begin
                e_treq[t] = 1'b1;
                if (t_gnt[t]) e_gnt[own[t]] = 1'b1;
            end
        end
        for (int i = 0; i < NI; i++) begin
            if (g_resetn && tgt[i] == -1) e_gnt[i] = 1'b1;
        end

        chk("i_gnt", 64'(i_gnt), 64'(e_gnt));
        chk("t_req", 64'(t_req), 64'(e_treq));
        for (int t = 0; t < NT; t++) begin
            if (own[t] >= 0) begin
                chk($sformatf("t_addr%0d", t), 64'(t_addr[t*AW +: AW]), 64'(p_addr[own[t]]));
                chk($sformatf("t_wen%0d", t), 64'(t_wen[t]), 64'(p_wen[own[t]]));
                chk($sformatf("t_strb%0d", t), 64'(t_strb[t*SW +: SW]), 64'(p_strb[own[t]]));
                chk($sformatf("t_wdata%0d", t), t_wdata[t*DW +: DW], p_wdata[own[t]]);
            end
        end
        for (int i = 0; i < NI; i++) begin
            e_rd  = '0;
            e_err = 1'b0;
            if (g_resetn && m_vld[i]) begin
                if (m_src[i] < 0) begin
                    e_err = 1'b1;
                end else begin
                    e_rd  = t_rdata[m_src[i]*DW +: DW];
                    e_err = t_err[m_src[i]];
                end
            end
            chk($sformatf("i_rdata%0d", i), i_rdata[i*DW +: DW], e_rd);
            chk($sformatf("i_err%0d", i), 64'(i_err[i]), 64'(e_err));
        end

        if (!g_resetn) begin
            for (int t = 0; t < NT; t++) begin
                m_ptr[t]  = 0;
                m_hold[t] = -1;
            end
            for (int i = 0; i < NI; i++) m_vld[i] = 1'b0;
        end else begin
            for (int t = 0; t < NT; t++) begin
                if (own[t] >= 0) begin
                    if (t_gnt[t]) begin
                        m_ptr[t]  = (own[t] + 1) % NI;
                        m_hold[t] = -1;
                    end else begin
                        m_hold[t] = own[t];
                    end
                end
            end
            for (int i = 0; i < NI; i++) begin
                m_vld[i] = e_gnt[i];
                if (e_gnt[i]) begin
                    m_src[i] = tgt[i];
                    p_act[i] = 1'b0;
                end
            end
        end
    endtask

    initial begin
        g_resetn = 1'b0;
        i_req    = '0;
        i_addr   = '0;
        i_wen    = '0;
        i_strb   = '0;
        i_wdata  = '0;
        t_gnt    = '0;
        t_err    = '0;
        t_rdata  = '0;
        for (int i = 0; i < NI; i++) begin
            p_act[i]   = 1'b0;
            p_addr[i]  = '0;
            p_wen[i]   = 1'b0;
            p_strb[i]  = '0;
            p_wdata[i] = '0;
            m_vld[i]   = 1'b0;
            m_src[i]   = 0;
        end
        for (int t = 0; t < NT; t++) begin
            m_ptr[t]  = 0;
            m_hold[t] = -1;
        end
        @(posedge g_clk);
        #1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            g_resetn = !(cyc < 3 || (cyc % 700) == 350 || (cyc % 700) == 351);
            for (int i = 0; i < NI; i++) begin
                if (!p_act[i] && $urandom_range(0, 3) != 0) begin
                    p_act[i]   = 1'b1;
                    p_addr[i]  = rand_addr();
                    p_wen[i]   = ($urandom_range(0, 1) == 1);
                    p_strb[i]  = SW'($urandom);
                    p_wdata[i] = {$urandom, $urandom};
                end
                i_req[i]            = p_act[i];
                i_addr[i*AW +: AW]  = p_addr[i];
                i_wen[i]            = p_wen[i];
                i_strb[i*SW +: SW]  = p_strb[i];
                i_wdata[i*DW +: DW] = p_wdata[i];
            end
            for (int t = 0; t < NT; t++) begin
                t_gnt[t]            = ($urandom_range(0, 9) < 7);
                t_err[t]            = ($urandom_range(0, 7) == 0);
                t_rdata[t*DW +: DW] = {$urandom, $urandom};
            end
            #4;
            eval_cycle();
            @(posedge g_clk);
            #1;
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
